// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flush and multi-cycle mult/div hold.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int MD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       usesRt_id,
    input  logic       branchTaken_id,
    input  logic       memRead_exe,
    input  logic [4:0] outReg_exe,
    input  logic       mdStart_exe,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_write,
    output logic       idex_bubble,
    output logic       exmem_bubble,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic {RUN, MDWAIT} state_t;

    // cnt counts the remaining held cycles after the first MDWAIT cycle
    localparam logic [3:0] CNT_LOAD = 4'(MD_CYCLES - 2);

    state_t     state;
    logic [3:0] cnt;
    logic       load_use;

    assign load_use = memRead_exe && (outReg_exe != 5'd0) &&
                      ((outReg_exe == rs_id) || (usesRt_id && (outReg_exe == rt_id)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mdStart_exe) begin
                        state <= MDWAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                MDWAIT: begin
                    if (cnt == 4'd0) state <= RUN;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (state == MDWAIT) begin
            // ID/EX inputs are held instructions here, so they are not examined
            md_busy = 1'b1;
            if (cnt == 4'd0) begin
                md_done = 1'b1;
            end else begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
            end
        end else if (mdStart_exe) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
        end else if (load_use) begin
            // branch resolution is deferred until the stalled operand is ready
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (branchTaken_id) begin
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= 16'd0;
        else if (!pc_write && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule
